mvau_act_feeder: RTL and testbench



---
 rtl/mvau_act_feeder_if.sv | 21 ++
 rtl/mvau_act_feeder.sv | 107 ++++++++++
 tb/tb_mvau_act_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mvau_act_feeder_if.sv
// rtl/mvau_act_feeder_if.sv - activation stream bundle between upstream source, feeder and MVAU
interface mvau_act_feeder_if #(
  parameter int TI = 8
);
  logic [TI-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [TI-1:0] m_data;
  logic          m_valid;
  logic          busy;

  modport master (
    output s_data, s_valid,
    input  s_ready, m_data, m_valid, busy
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, m_data, m_valid, busy
  );
endinterface

// File: rtl/mvau_act_feeder.sv
// rtl/mvau_act_feeder.sv - buffers one activation vector and replays it NF times into the MVAU
module mvau_act_feeder #(
  parameter int SIMD    = 2,
  parameter int TSrcI   = 4,
  parameter int MatrixW = 8,
  parameter int MatrixH = 4,
  parameter int PE      = 2
) (
  input  logic               clk,
  input  logic               rst,
  mvau_act_feeder_if.slave   bus
);
  localparam int TI    = SIMD * TSrcI;
  localparam int SF    = MatrixW / SIMD;
  localparam int NF    = MatrixH / PE;
  localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;

  typedef enum logic {FILL, REPLAY} state_e;

  state_e            state_q, state_d;
  logic [SF_BW-1:0]  wcnt_q, wcnt_d;
  logic [NF_BW-1:0]  pcnt_q, pcnt_d;
  logic [TI-1:0]     m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [TI-1:0]     vbuf_q [SF];
  logic              vbuf_we;
  logic              s_ready;
  logic              accept;
  logic              last_word;

  assign s_ready   = (state_q == FILL);
  assign accept    = bus.s_valid & s_ready;
  assign last_word = (wcnt_q == SF_BW'(SF - 1));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    vbuf_we   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          vbuf_we   = 1'b1;
          m_data_d  = bus.s_data;
          m_valid_d = 1'b1;
          if (last_word) begin
            wcnt_d = '0;
            // With a single chunk there is nothing to replay; stay a plain register stage.
            if (NF > 1) begin
              pcnt_d  = NF_BW'(1);
              state_d = REPLAY;
            end
          end else begin
            wcnt_d = wcnt_q + SF_BW'(1);
          end
        end
      end
      REPLAY: begin
        m_data_d  = vbuf_q[wcnt_q];
        m_valid_d = 1'b1;
        if (last_word) begin
          wcnt_d = '0;
          if (pcnt_q == NF_BW'(NF - 1)) begin
            pcnt_d  = '0;
            state_d = FILL;
          end else begin
            pcnt_d = pcnt_q + NF_BW'(1);
          end
        end else begin
          wcnt_d = wcnt_q + SF_BW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Vector storage carries no reset; it is only read after being fully written.
  always_ff @(posedge clk) begin
    if (vbuf_we) begin
      vbuf_q[wcnt_q] <= bus.s_data;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = (state_q == REPLAY) | (wcnt_q != '0);
endmodule

// File: tb/tb_mvau_act_feeder.sv
// tb/tb_mvau_act_feeder.sv - directed self-checking bench for mvau_act_feeder
module tb_mvau_act_feeder;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  int q_iv[$];
  int q_id[$];
  int q_er[$];
  int q_ev[$];
  int q_ed[$];
  int q_eb[$];

  mvau_act_feeder_if #(.TI(8)) bi0 ();
  mvau_act_feeder_if #(.TI(8)) bi1 ();

  mvau_act_feeder #(
    .SIMD(2), .TSrcI(4), .MatrixW(8), .MatrixH(4), .PE(2)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bi0.slave)
  );

  mvau_act_feeder #(
    .SIMD(2), .TSrcI(4), .MatrixW(4), .MatrixH(2), .PE(2)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bi1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input string tag, input int sel);
    logic [31:0] o_rdy, o_mv, o_md, o_bz;
    for (int t = 0; t < q_iv.size(); t++) begin
      @(negedge clk);
      if (sel == 0) begin
        bi0.s_valid = q_iv[t][0];
        bi0.s_data  = q_id[t][7:0];
        o_rdy       = {31'd0, bi0.s_ready};
      end else begin
        bi1.s_valid = q_iv[t][0];
        bi1.s_data  = q_id[t][7:0];
        o_rdy       = {31'd0, bi1.s_ready};
      end
      chk($sformatf("%s s_ready t%0d", tag, t), o_rdy, q_er[t]);
      @(posedge clk);
      #1;
      o_mv = (sel == 0) ? {31'd0, bi0.m_valid} : {31'd0, bi1.m_valid};
      o_md = (sel == 0) ? {24'd0, bi0.m_data}  : {24'd0, bi1.m_data};
      o_bz = (sel == 0) ? {31'd0, bi0.busy}    : {31'd0, bi1.busy};
      chk($sformatf("%s m_valid t%0d", tag, t), o_mv, q_ev[t]);
      if (q_ev[t] != 0) chk($sformatf("%s m_data t%0d", tag, t), o_md, q_ed[t]);
      chk($sformatf("%s busy t%0d", tag, t), o_bz, q_eb[t]);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bi0.s_valid = 1'b0;
    bi0.s_data  = 8'h00;
    bi1.s_valid = 1'b0;
    bi1.s_data  = 8'h00;

    // Reset held with random upstream activity
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bi0.s_valid = 1'($urandom_range(0, 1));
      bi0.s_data  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst m_valid", {31'd0, bi0.m_valid}, 0);
      chk("rst m_data", {24'd0, bi0.m_data}, 0);
      chk("rst busy", {31'd0, bi0.busy}, 0);
      chk("rst dut1 m_valid", {31'd0, bi1.m_valid}, 0);
    end
    @(negedge clk);
    rst         = 1'b0;
    bi0.s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst s_ready", {31'd0, bi0.s_ready}, 1);
    chk("post-rst m_valid", {31'd0, bi0.m_valid}, 0);
    chk("post-rst busy", {31'd0, bi0.busy}, 0);

    // Single vector
    q_iv = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    q_id = '{'h11, 'h22, 'h33, 'h44, 0, 0, 0, 0, 0};
    q_er = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    q_ev = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    q_ed = '{'h11, 'h22, 'h33, 'h44, 'h11, 'h22, 'h33, 'h44, 0};
    q_eb = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    run_seq("single", 0);

    // Gapped fill; gap cycles carry junk data that must not be taken
    q_iv = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    q_id = '{'hA1, 'hEE, 'hA2, 'hEE, 'hA3, 'hEE, 'hA4, 0, 0, 0, 0, 0};
    q_er = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    q_ev = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0};
    q_ed = '{'hA1, 0, 'hA2, 0, 'hA3, 0, 'hA4, 'hA1, 'hA2, 'hA3, 'hA4, 0};
    q_eb = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    run_seq("gapped", 0);

    // Back-to-back vectors with s_valid held high; 05 waits while replaying
    q_iv = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    q_id = '{1, 2, 3, 4, 5, 5, 5, 5, 5, 6, 7, 8, 9, 9, 9, 9, 0};
    q_er = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    q_ev = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    q_ed = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8, 0};
    q_eb = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    run_seq("b2b", 0);

    // Reset after the 6th output of a vector
    q_iv = '{1, 1, 1, 1, 0, 0};
    q_id = '{'hC1, 'hC2, 'hC3, 'hC4, 0, 0};
    q_er = '{1, 1, 1, 1, 0, 0};
    q_ev = '{1, 1, 1, 1, 1, 1};
    q_ed = '{'hC1, 'hC2, 'hC3, 'hC4, 'hC1, 'hC2};
    q_eb = '{1, 1, 1, 1, 1, 1};
    run_seq("pre-rst", 0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst m_valid", {31'd0, bi0.m_valid}, 0);
    chk("midrst busy", {31'd0, bi0.busy}, 0);
    chk("midrst s_ready", {31'd0, bi0.s_ready}, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_iv = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    q_id = '{'hB1, 'hB2, 'hB3, 'hB4, 0, 0, 0, 0, 0};
    q_er = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    q_ev = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    q_ed = '{'hB1, 'hB2, 'hB3, 'hB4, 'hB1, 'hB2, 'hB3, 'hB4, 0};
    q_eb = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    run_seq("post-midrst", 0);

    // SF=2, NF=1: pass-through register, never replays
    q_iv = '{1, 1, 0, 1, 1, 1, 0, 0};
    q_id = '{'h5A, 'h3C, 'hEE, 'h7E, 'h81, 'h99, 'hEE, 0};
    q_er = '{1, 1, 1, 1, 1, 1, 1, 1};
    q_ev = '{1, 1, 0, 1, 1, 1, 0, 0};
    q_ed = '{'h5A, 'h3C, 0, 'h7E, 'h81, 'h99, 0, 0};
    q_eb = '{1, 0, 0, 1, 0, 1, 1, 1};
    run_seq("nf1", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
